tile_painter: RTL and testbench

Parametrised rectangular-tile rasteriser for the minesweeper game board. On a `go` pulse it latches a tile origin, fill colour and optional border colour, then emits one pixel per clock (`x`, `y`, `color`, `plot`) for a TILE_W × TILE_H tile, row-major, straight into the VGA adapter's plot port. It sits between the board-level cell sequencer, which issues one tile per mine/flag/step cell, and the VGA adapter. It replaces the fixed-size per-tile drawing FSM with a counter-driven scan that adds border mode, off-screen clipping and a `done` handshake.

---
 rtl/gameboard_pkg.sv | 22 ++
 rtl/tile_painter_if.sv | 30 +++
 rtl/tile_scan_counter.sv | 41 ++++
 rtl/tile_painter.sv | 138 +++++++++++++
 tb/tb_tile_painter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/gameboard_pkg.sv
// Shared definitions for the minesweeper game-board drawing blocks:
// painter state encoding, default tile/screen geometry and palette constants.
package gameboard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } paint_state_t;

  localparam int DEF_TILE_W   = 20;
  localparam int DEF_TILE_H   = 15;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_RED   = 3'b100;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

endpackage

// File: rtl/tile_painter_if.sv
// Tile request / pixel plot bundle between the cell sequencer, the tile
// painter and the VGA adapter plot port.
interface tile_painter_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic               go;
  logic [X_W-1:0]     x_in;
  logic [Y_W-1:0]     y_in;
  logic [COLOR_W-1:0] color_in;
  logic [COLOR_W-1:0] border_color_in;
  logic               border_en;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
    output go, x_in, y_in, color_in, border_color_in, border_en,
    input  x, y, color, plot, busy, done
  );

  modport slave (
    input  go, x_in, y_in, color_in, border_color_in, border_en,
    output x, y, color, plot, busy, done
  );
endinterface

// File: rtl/tile_scan_counter.sv
// Row-major dx/dy scan counter over a W x H tile; wraps to (0,0) after the
// last pixel and flags the last column and the last pixel.
module tile_scan_counter #(
  parameter int W = 20,
  parameter int H = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  output logic [$clog2(W)-1:0] dx,
  output logic [$clog2(H)-1:0] dy,
  output logic                 last_col,
  output logic                 last_pix
);
  localparam int DXW = $clog2(W);
  localparam int DYW = $clog2(H);
  localparam logic [DXW-1:0] LAST_DX = DXW'(W - 1);
  localparam logic [DYW-1:0] LAST_DY = DYW'(H - 1);

  assign last_col = (dx == LAST_DX);
  assign last_pix = last_col && (dy == LAST_DY);

  // NOTE: reset is synchronous and active-low, so it only appears inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (en) begin
      if (last_col) begin
        dx <= '0;
        dy <= last_pix ? '0 : dy + 1'b1;
      end else begin
        dx <= dx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tile_painter.sv
// Rectangular tile rasteriser: one registered pixel per clock, row-major,
// with optional 1-pixel border, off-screen clipping and a done pulse.
module tile_painter
  import gameboard_pkg::*;
#(
  parameter int TILE_W   = DEF_TILE_W,
  parameter int TILE_H   = DEF_TILE_H,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3
) (
  input logic           clk,
  input logic           reset,
  tile_painter_if.slave bus
);
  localparam int DXW = $clog2(TILE_W);
  localparam int DYW = $clog2(TILE_H);
  localparam logic [DXW-1:0] LAST_DX = DXW'(TILE_W - 1);
  localparam logic [DYW-1:0] LAST_DY = DYW'(TILE_H - 1);

  paint_state_t       state;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [COLOR_W-1:0] fill_q, border_q;
  logic               border_en_q;

  logic [DXW-1:0]     dx, nx;
  logic [DYW-1:0]     dy, ny;
  logic               last_col, last_pix;

  logic [X_W-1:0]     ox;
  logic [Y_W-1:0]     oy;
  logic [COLOR_W-1:0] ofill, oborder;
  logic               oben;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;
  logic               on_edge;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_plot;

  // Counter tracks the pixel currently shown on the registered outputs.
  tile_scan_counter #(.W(TILE_W), .H(TILE_H)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state == IDLE) && bus.go),
    .en       (state == DRAW),
    .dx       (dx),
    .dy       (dy),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // The output registers load the *next* pixel. Pixel 0 is built straight from
  // the request inputs so it reaches the outputs the cycle after go.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    ox      = x0;
    oy      = y0;
    ofill   = fill_q;
    oborder = border_q;
    oben    = border_en_q;
    nx      = last_col ? '0 : dx + 1'b1;
    ny      = last_col ? dy + 1'b1 : dy;
    if (state == IDLE) begin
      ox      = bus.x_in;
      oy      = bus.y_in;
      ofill   = bus.color_in;
      oborder = bus.border_color_in;
      oben    = bus.border_en;
      nx      = '0;
      ny      = '0;
    end
    sum_x     = {1'b0, ox} + (X_W+1)'(nx);
    sum_y     = {1'b0, oy} + (Y_W+1)'(ny);
    on_edge   = (nx == '0) || (nx == LAST_DX) || (ny == '0) || (ny == LAST_DY);
    pix_color = (oben && on_edge) ? oborder : ofill;
    pix_plot  = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
  end

  // NOTE: all state and output registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      x0          <= '0;
      y0          <= '0;
      fill_q      <= '0;
      border_q    <= '0;
      border_en_q <= 1'b0;
      bus.x       <= '0;
      bus.y       <= '0;
      bus.color   <= '0;
      bus.plot    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.plot <= 1'b0;
          bus.done <= 1'b0;
          if (bus.go) begin
            x0          <= bus.x_in;
            y0          <= bus.y_in;
            fill_q      <= bus.color_in;
            border_q    <= bus.border_color_in;
            border_en_q <= bus.border_en;
            bus.x       <= sum_x[X_W-1:0];
            bus.y       <= sum_y[Y_W-1:0];
            bus.color   <= pix_color;
            bus.plot    <= pix_plot;
            bus.busy    <= 1'b1;
            state       <= DRAW;
          end
        end
        DRAW: begin
          if (last_pix) begin
            bus.plot <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            bus.x     <= sum_x[X_W-1:0];
            bus.y     <= sum_y[Y_W-1:0];
            bus.color <= pix_color;
            bus.plot  <= pix_plot;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_painter.sv
// Directed bench for tile_painter: default 20x15 instance plus a 4x2 instance
// for the coordinate-overflow clipping corner.
module tb_tile_painter;
  import gameboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tile_painter_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) bus ();
  tile_painter_if #(.X_W(8), .Y_W(7), .COLOR_W(3)) bus2 ();

  tile_painter #(.TILE_W(20), .TILE_H(15), .SCREEN_W(160), .SCREEN_H(120),
                 .X_W(8), .Y_W(7), .COLOR_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  tile_painter #(.TILE_W(4), .TILE_H(2), .SCREEN_W(160), .SCREEN_H(120),
                 .X_W(8), .Y_W(7), .COLOR_W(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [7:0] cap_x [0:615];
  logic [6:0] cap_y [0:615];
  logic [2:0] cap_c [0:615];
  logic       cap_p [0:615];
  logic       cap_b [0:615];
  logic       cap_d [0:615];

  int plot_cnt, done_cnt, first_plot, last_plot, first_done, last_done;

  task automatic drive_req(input logic [7:0] xi, input logic [6:0] yi,
                           input logic [2:0] fill, input logic [2:0] bord, input logic ben);
    @(negedge clk);
    bus.x_in = xi; bus.y_in = yi; bus.color_in = fill;
    bus.border_color_in = bord; bus.border_en = ben; bus.go = 1'b1;
  endtask

  // Sample j is the cycle E0+j where E0 is the edge that accepted go.
  task automatic capture(input int ncyc, input int hold, input int pulse_a,
                         input int pulse_b, input bit scramble);
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      cap_x[j] = bus.x; cap_y[j] = bus.y; cap_c[j] = bus.color;
      cap_p[j] = bus.plot; cap_b[j] = bus.busy; cap_d[j] = bus.done;
      bus.go = (j < hold) || (j == pulse_a) || (j == pulse_b);
      if (scramble && j == 1) begin
        bus.x_in = 8'd77; bus.y_in = 7'd3; bus.color_in = 3'b001;
        bus.border_color_in = 3'b110; bus.border_en = ~bus.border_en;
      end
    end
  endtask

  task automatic summarize(input int n);
    plot_cnt = 0; done_cnt = 0; first_plot = -1; last_plot = -1;
    first_done = -1; last_done = -1;
    for (int j = 1; j <= n; j++) begin
      if (cap_p[j]) begin
        plot_cnt++;
        if (first_plot < 0) first_plot = j;
        last_plot = j;
      end
      if (cap_d[j]) begin
        done_cnt++;
        if (first_done < 0) first_done = j;
        last_done = j;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.go = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.color_in = '0;
    bus.border_color_in = '0; bus.border_en = 1'b0;
    bus2.go = 1'b0; bus2.x_in = '0; bus2.y_in = '0; bus2.color_in = '0;
    bus2.border_color_in = '0; bus2.border_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.x, bus.y, bus.color} !== 18'd0) begin errors++; $display("FAIL reset_xyc: got %0h expected 0", {bus.x, bus.y, bus.color}); end
    checks++; if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.plot, bus.busy, bus.done}); end
    checks++; if ({bus2.plot, bus2.busy, bus2.done} !== 3'b000) begin errors++; $display("FAIL reset_flags_small: got %b expected 000", {bus2.plot, bus2.busy, bus2.done}); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int bad_pos, bad_col;
    drive_req(8'd20, 7'd15, 3'b101, 3'b000, 1'b0);
    capture(305, 1, 0, 0, 1'b1);
    summarize(305);
    bad_pos = 0; bad_col = 0;
    for (int k = 0; k < 300; k++) begin
      if (cap_x[k+1] !== 8'(20 + k % 20) || cap_y[k+1] !== 7'(15 + k / 20) || cap_p[k+1] !== 1'b1) bad_pos++;
      if (cap_c[k+1] !== 3'b101) bad_col++;
    end
    checks++; if (plot_cnt !== 300) begin errors++; $display("FAIL basic_plots: got %0d expected 300", plot_cnt); end
    checks++; if (first_plot !== 1 || cap_x[1] !== 8'd20 || cap_y[1] !== 7'd15) begin errors++; $display("FAIL basic_first: got cyc %0d (%0d,%0d) expected cyc 1 (20,15)", first_plot, cap_x[1], cap_y[1]); end
    checks++; if (last_plot !== 300 || cap_x[300] !== 8'd39 || cap_y[300] !== 7'd29) begin errors++; $display("FAIL basic_last: got cyc %0d (%0d,%0d) expected cyc 300 (39,29)", last_plot, cap_x[300], cap_y[300]); end
    checks++; if (bad_pos !== 0) begin errors++; $display("FAIL basic_raster_order: got %0d bad pixels expected 0", bad_pos); end
    checks++; if (bad_col !== 0) begin errors++; $display("FAIL basic_color: got %0d bad colours expected 0", bad_col); end
    checks++; if (first_done !== 301 || done_cnt !== 1) begin errors++; $display("FAIL basic_done: got cyc %0d count %0d expected cyc 301 count 1", first_done, done_cnt); end
    checks++; if ({cap_b[1], cap_b[301], cap_b[302]} !== 3'b110) begin errors++; $display("FAIL basic_busy: got %b expected 110", {cap_b[1], cap_b[301], cap_b[302]}); end
  endtask

  task automatic test_border;
    int n_border, n_fill, bad;
    logic [2:0] exp_c;
    drive_req(8'd0, 7'd0, 3'b010, 3'b111, 1'b1);
    capture(305, 1, 0, 0, 1'b0);
    n_border = 0; n_fill = 0; bad = 0;
    for (int k = 0; k < 300; k++) begin
      exp_c = (k % 20 == 0 || k % 20 == 19 || k / 20 == 0 || k / 20 == 14) ? 3'b111 : 3'b010;
      if (cap_c[k+1] !== exp_c) bad++;
      if (cap_p[k+1] && cap_c[k+1] === 3'b111) n_border++;
      if (cap_p[k+1] && cap_c[k+1] === 3'b010) n_fill++;
    end
    checks++; if (n_border !== 66 || n_fill !== 234) begin errors++; $display("FAIL border_counts: got %0d/%0d expected 66/234", n_border, n_fill); end
    checks++; if (cap_c[22] !== 3'b010) begin errors++; $display("FAIL border_pix_1_1: got %b expected 010", cap_c[22]); end
    checks++; if (cap_c[300] !== 3'b111) begin errors++; $display("FAIL border_pix_19_14: got %b expected 111", cap_c[300]); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL border_map: got %0d bad pixels expected 0", bad); end
  endtask

  task automatic test_clip;
    int bad;
    drive_req(8'd150, 7'd110, 3'b011, 3'b000, 1'b0);
    capture(305, 1, 0, 0, 1'b0);
    summarize(305);
    bad = 0;
    for (int k = 0; k < 300; k++)
      if (cap_p[k+1] !== ((k % 20 < 10) && (k / 20 < 10))) bad++;
    checks++; if (plot_cnt !== 100) begin errors++; $display("FAIL clip_plots: got %0d expected 100", plot_cnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clip_map: got %0d bad pixels expected 0", bad); end
    checks++; if (first_done !== 301) begin errors++; $display("FAIL clip_done: got cyc %0d expected 301", first_done); end
  endtask

  task automatic test_back_to_back;
    int second_plot;
    drive_req(8'd40, 7'd30, 3'b110, 3'b000, 1'b0);
    capture(610, 600, 0, 0, 1'b0);
    summarize(610);
    second_plot = -1;
    for (int j = 302; j <= 610; j++)
      if (cap_p[j] && second_plot < 0) second_plot = j;
    checks++; if (plot_cnt !== 600 || done_cnt !== 2) begin errors++; $display("FAIL b2b_tiles: got %0d plots %0d dones expected 600 plots 2 dones", plot_cnt, done_cnt); end
    checks++; if (first_done !== 301 || last_done !== 603) begin errors++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 301,603", first_done, last_done); end
    checks++; if (second_plot - first_plot !== 302) begin errors++; $display("FAIL b2b_spacing: got %0d expected 302", second_plot - first_plot); end
    checks++; if (cap_b[302] !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b expected 0", cap_b[302]); end
    drive_req(8'd60, 7'd45, 3'b001, 3'b000, 1'b0);
    capture(305, 1, 50, 301, 1'b0);
    summarize(305);
    checks++; if (cap_x[52] !== 8'd71 || cap_y[52] !== 7'd47) begin errors++; $display("FAIL go_in_draw: got (%0d,%0d) expected (71,47)", cap_x[52], cap_y[52]); end
    checks++; if (plot_cnt !== 300 || done_cnt !== 1 || cap_b[303] !== 1'b0) begin errors++; $display("FAIL go_in_done: got %0d plots %0d dones busy %b expected 300 1 0", plot_cnt, done_cnt, cap_b[303]); end
  endtask

  task automatic test_reset_mid;
    int n_plot, n_done;
    drive_req(8'd0, 7'd0, 3'b101, 3'b000, 1'b0);
    capture(58, 1, 0, 0, 1'b0);
    checks++; if (cap_x[58] !== 8'd17 || cap_y[58] !== 7'd2) begin errors++; $display("FAIL rst_pix57: got (%0d,%0d) expected (17,2)", cap_x[58], cap_y[58]); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 000", {bus.plot, bus.busy, bus.done}); end
    reset = 1'b1;
    n_plot = 0; n_done = 0;
    for (int j = 0; j < 320; j++) begin
      @(negedge clk);
      if (bus.plot) n_plot++;
      if (bus.done) n_done++;
    end
    checks++; if (n_plot !== 0 || n_done !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d plots %0d dones expected 0 0", n_plot, n_done); end
    drive_req(8'd5, 7'd6, 3'b011, 3'b000, 1'b0);
    capture(305, 1, 0, 0, 1'b0);
    summarize(305);
    checks++; if (cap_p[1] !== 1'b1 || cap_x[1] !== 8'd5 || cap_y[1] !== 7'd6) begin errors++; $display("FAIL rst_restart: got plot %b (%0d,%0d) expected 1 (5,6)", cap_p[1], cap_x[1], cap_y[1]); end
    checks++; if (first_done !== 301 || plot_cnt !== 300) begin errors++; $display("FAIL rst_restart_done: got cyc %0d plots %0d expected 301 300", first_done, plot_cnt); end
  endtask

  task automatic run_small(input logic [7:0] xi, output int n_plot, output int done_at,
                           output int bad_plot, output int bad_x, output int bad_c);
    @(negedge clk);
    bus2.x_in = xi; bus2.y_in = 7'd0; bus2.color_in = 3'b010;
    bus2.border_color_in = 3'b100; bus2.border_en = 1'b1; bus2.go = 1'b1;
    n_plot = 0; done_at = -1; bad_plot = 0; bad_x = 0; bad_c = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      bus2.go = 1'b0;
      if (bus2.plot) n_plot++;
      if (bus2.done && done_at < 0) done_at = j;
      if (j <= 8) begin
        if (bus2.plot !== (int'(xi) + (j - 1) % 4 < 160)) bad_plot++;
        if (bus2.x !== 8'(int'(xi) + (j - 1) % 4)) bad_x++;
        if (bus2.color !== 3'b100) bad_c++;
      end
    end
  endtask

  task automatic test_wide;
    int n_plot, done_at, bad_plot, bad_x, bad_c;
    run_small(8'd254, n_plot, done_at, bad_plot, bad_x, bad_c);
    checks++; if (n_plot !== 0) begin errors++; $display("FAIL wide_no_wrap: got %0d plots expected 0", n_plot); end
    checks++; if (done_at !== 9 || bad_x !== 0) begin errors++; $display("FAIL wide_timing: got done %0d badx %0d expected 9 0", done_at, bad_x); end
    checks++; if (bad_c !== 0) begin errors++; $display("FAIL wide_all_border: got %0d bad colours expected 0", bad_c); end
    run_small(8'd157, n_plot, done_at, bad_plot, bad_x, bad_c);
    checks++; if (n_plot !== 6 || bad_plot !== 0) begin errors++; $display("FAIL edge_clip: got %0d plots %0d bad expected 6 0", n_plot, bad_plot); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_border;
    test_clip;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
